mem_xlate_stage: RTL and testbench

- Memory-stage front end. Consumes the address-stage pipeline latch outputs: valid, linear address, segment offset/limit, opSize and the memory-op control bits.
- Checks the segment limit, translates the linear address through a small fully-associative TLB, and splits page-crossing accesses into two sequential translations.
- Produces registered physical address(es) and exception status for the D-cache access stage. Back-pressures the upstream latch through a stall output.

---
 rtl/mem_pkg.sv | 48 ++++
 rtl/mem_xlate_stage_if.sv | 47 ++++
 rtl/tlb_cam.sv | 57 +++++
 rtl/mem_xlate_stage.sv | 138 +++++++++++++
 tb/tb_mem_xlate_stage.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage address translation front end.
// Covers access-size encodings, exception codes, page geometry and FSM states.
package mem_pkg;

    localparam int PAGE_BITS = 12;
    localparam int VPN_W     = 32 - PAGE_BITS;
    localparam int PAGE_SIZE = 1 << PAGE_BITS;

    typedef enum logic [1:0] {
        SZ_1B = 2'b00,
        SZ_2B = 2'b01,
        SZ_4B = 2'b10,
        SZ_8B = 2'b11
    } op_size_e;

    typedef enum logic [1:0] {
        EXC_NONE  = 2'b00,
        EXC_GP    = 2'b01,
        EXC_PF_NP = 2'b10,
        EXC_PF_WP = 2'b11
    } exc_code_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SPLIT2 = 1'b1
    } xlate_state_e;

    typedef struct packed {
        logic present;
        logic writable;
    } tlb_flags_t;

    typedef struct packed {
        logic        v;
        logic        rd;
        logic        wr;
        logic        split;
        logic        exc_v;
        logic [1:0]  exc_code;
        logic [31:0] pa0;
        logic [31:0] pa1;
    } xlate_out_t;

    function automatic logic [3:0] op_bytes(input logic [1:0] op_size);
        return 4'd1 << op_size;
    endfunction

endpackage

// File: rtl/mem_xlate_stage_if.sv
// Bus bundle between the address-stage latch, the TLB fill path and the D-cache stage.
// The translation stage sits on the slave side; the driver of the pipeline is the master.
interface mem_xlate_stage_if #(
    parameter int TLB_ENTRIES = 8
);
    import mem_pkg::*;

    localparam int IDX_W = $clog2(TLB_ENTRIES);

    logic              i_v;
    logic              i_mem_rd;
    logic              i_mem_wr;
    logic [31:0]       i_lin_addr;
    logic [31:0]       i_seg_off;
    logic [31:0]       i_seg_lim;
    logic [1:0]        i_opSize;
    logic              i_flush;
    logic              i_dc_stall;
    logic              i_fill_we;
    logic [IDX_W-1:0]  i_fill_idx;
    logic [VPN_W-1:0]  i_fill_vpn;
    logic [VPN_W-1:0]  i_fill_pfn;
    logic [1:0]        i_fill_flags;

    logic              o_stall;
    logic              o_v;
    logic              o_mem_rd;
    logic              o_mem_wr;
    logic [31:0]       o_pa0;
    logic [31:0]       o_pa1;
    logic              o_split;
    logic              o_exc_v;
    logic [1:0]        o_exc_code;

    modport master (
        output i_v, i_mem_rd, i_mem_wr, i_lin_addr, i_seg_off, i_seg_lim, i_opSize,
               i_flush, i_dc_stall, i_fill_we, i_fill_idx, i_fill_vpn, i_fill_pfn, i_fill_flags,
        input  o_stall, o_v, o_mem_rd, o_mem_wr, o_pa0, o_pa1, o_split, o_exc_v, o_exc_code
    );

    modport slave (
        input  i_v, i_mem_rd, i_mem_wr, i_lin_addr, i_seg_off, i_seg_lim, i_opSize,
               i_flush, i_dc_stall, i_fill_we, i_fill_idx, i_fill_vpn, i_fill_pfn, i_fill_flags,
        output o_stall, o_v, o_mem_rd, o_mem_wr, o_pa0, o_pa1, o_split, o_exc_v, o_exc_code
    );

endinterface

// File: rtl/tlb_cam.sv
// Fully-associative TLB: per-entry storage, single fill write port and parallel VPN compare.
// Lookup reads the registered contents, so a same-cycle fill is only visible after the edge.
module tlb_cam
    import mem_pkg::*;
#(
    parameter  int ENTRIES = 8,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_fill_we,
    input  logic [IDX_W-1:0] i_fill_idx,
    input  logic [VPN_W-1:0] i_fill_vpn,
    input  logic [VPN_W-1:0] i_fill_pfn,
    input  tlb_flags_t       i_fill_flags,
    input  logic [VPN_W-1:0] i_lk_vpn,
    output logic             o_hit,
    output logic [VPN_W-1:0] o_pfn,
    output tlb_flags_t       o_flags
);

    logic [ENTRIES-1:0] r_valid;
    logic [VPN_W-1:0]   r_vpn   [ENTRIES];
    logic [VPN_W-1:0]   r_pfn   [ENTRIES];
    logic [1:0]         r_flags [ENTRIES];
    logic [1:0]         w_flags;

    // NOTE: only the valid bits are reset; payload is never observed until its entry is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_valid             <= '0;
        else if (i_fill_we) r_valid[i_fill_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (i_fill_we) begin
            r_vpn[i_fill_idx]   <= i_fill_vpn;
            r_pfn[i_fill_idx]   <= i_fill_pfn;
            r_flags[i_fill_idx] <= i_fill_flags;
        end
    end

    // Fill software guarantees at most one match, so an OR-reduction is a valid mux.
    always_comb begin
        o_hit   = 1'b0;
        o_pfn   = '0;
        w_flags = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_vpn[i] == i_lk_vpn)) begin
                o_hit   = 1'b1;
                o_pfn   = o_pfn | r_pfn[i];
                w_flags = w_flags | r_flags[i];
            end
        end
        o_flags = tlb_flags_t'(w_flags);
    end

endmodule

// File: rtl/mem_xlate_stage.sv
// Memory-stage front end: segment limit check, TLB translation and two-step handling of
// page-crossing accesses, producing registered physical addresses for the D-cache stage.
module mem_xlate_stage
    import mem_pkg::*;
#(
    parameter int TLB_ENTRIES = 8
) (
    input  logic              clk,
    input  logic              rst,
    mem_xlate_stage_if.slave  bus
);

    xlate_state_e          r_state, w_state_nxt;
    xlate_out_t            r_out, w_out_nxt;
    logic [VPN_W-1:0]      r_pfn0, w_pfn0_nxt;

    logic [3:0]            w_sz;
    logic [PAGE_BITS-1:0]  w_off;
    logic [VPN_W-1:0]      w_vpn, w_lk_vpn, w_pfn;
    logic [32:0]           w_seg_end;
    logic                  w_memop, w_cross, w_gp, w_hit;
    tlb_flags_t            w_flags;
    exc_code_e             w_exc;

    assign w_sz      = op_bytes(bus.i_opSize);
    assign w_off     = bus.i_lin_addr[PAGE_BITS-1:0];
    assign w_vpn     = bus.i_lin_addr[31:PAGE_BITS];
    assign w_memop   = bus.i_mem_rd | bus.i_mem_wr;
    // off + sz > PAGE_SIZE is the same as the last byte carrying into the next page.
    assign w_cross   = w_memop &
                       (({1'b0, w_off} + (PAGE_BITS+1)'(w_sz)) > (PAGE_BITS+1)'(PAGE_SIZE));
    assign w_seg_end = {1'b0, bus.i_seg_off} + 33'(w_sz) - 33'd1;
    assign w_gp      = w_seg_end > {1'b0, bus.i_seg_lim};
    assign w_lk_vpn  = (r_state == ST_SPLIT2) ? w_vpn + VPN_W'(1) : w_vpn;

    tlb_cam #(.ENTRIES(TLB_ENTRIES)) u_tlb (
        .clk          (clk),
        .rst          (rst),
        .i_fill_we    (bus.i_fill_we),
        .i_fill_idx   (bus.i_fill_idx),
        .i_fill_vpn   (bus.i_fill_vpn),
        .i_fill_pfn   (bus.i_fill_pfn),
        .i_fill_flags (tlb_flags_t'(bus.i_fill_flags)),
        .i_lk_vpn     (w_lk_vpn),
        .o_hit        (w_hit),
        .o_pfn        (w_pfn),
        .o_flags      (w_flags)
    );

    // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
    always_comb begin
        w_exc = EXC_NONE;
        if (w_gp)                                   w_exc = EXC_GP;
        else if (!w_hit || !w_flags.present)        w_exc = EXC_PF_NP;
        else if (bus.i_mem_wr && !w_flags.writable) w_exc = EXC_PF_WP;
    end

    // NOTE: state lives in always_ff with <=; combinational blocks use = only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_flush) begin
            w_state_nxt = ST_IDLE;
        end else if (!bus.i_dc_stall) begin
            case (r_state)
                ST_IDLE:   if (bus.i_v && w_cross && (w_exc == EXC_NONE)) w_state_nxt = ST_SPLIT2;
                ST_SPLIT2: w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_out_nxt  = r_out;
        w_pfn0_nxt = r_pfn0;
        if (bus.i_flush) begin
            w_out_nxt  = '0;
            w_pfn0_nxt = '0;
        end else if (!bus.i_dc_stall) begin
            w_out_nxt    = '0;
            w_out_nxt.rd = bus.i_v & bus.i_mem_rd;
            w_out_nxt.wr = bus.i_v & bus.i_mem_wr;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_v) begin
                        if (!w_memop) begin
                            w_out_nxt.v = 1'b1;
                        end else if (w_exc != EXC_NONE) begin
                            w_out_nxt.v        = 1'b1;
                            w_out_nxt.exc_v    = 1'b1;
                            w_out_nxt.exc_code = w_exc;
                        end else if (w_cross) begin
                            w_pfn0_nxt = w_pfn;
                        end else begin
                            w_out_nxt.v   = 1'b1;
                            w_out_nxt.pa0 = {w_pfn, w_off};
                        end
                    end
                end
                ST_SPLIT2: begin
                    w_out_nxt.v        = 1'b1;
                    w_out_nxt.split    = 1'b1;
                    w_out_nxt.pa0      = {r_pfn0, w_off};
                    w_out_nxt.pa1      = {w_pfn, {PAGE_BITS{1'b0}}};
                    w_out_nxt.exc_v    = (w_exc != EXC_NONE);
                    w_out_nxt.exc_code = w_exc;
                    w_pfn0_nxt         = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out  <= '0;
            r_pfn0 <= '0;
        end else begin
            r_out  <= w_out_nxt;
            r_pfn0 <= w_pfn0_nxt;
        end
    end

    assign bus.o_stall    = bus.i_dc_stall | (r_state == ST_SPLIT2);
    assign bus.o_v        = r_out.v;
    assign bus.o_mem_rd   = r_out.rd;
    assign bus.o_mem_wr   = r_out.wr;
    assign bus.o_pa0      = r_out.pa0;
    assign bus.o_pa1      = r_out.pa1;
    assign bus.o_split    = r_out.split;
    assign bus.o_exc_v    = r_out.exc_v;
    assign bus.o_exc_code = r_out.exc_code;

endmodule

// File: tb/tb_mem_xlate_stage.sv
// Self-checking bench for mem_xlate_stage: directed scenarios plus randomized accesses
// compared against a transaction-level model of segment check, TLB and page splitting.
module tb_mem_xlate_stage;
    import mem_pkg::*;

    localparam int N     = 8;
    localparam int IDX_W = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_xlate_stage_if #(.TLB_ENTRIES(N)) bus ();
    mem_xlate_stage #(.TLB_ENTRIES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    bit        m_v   [N];
    bit [19:0] m_vpn [N];
    bit [19:0] m_pfn [N];
    bit [1:0]  m_fl  [N];

    typedef struct {
        bit        split;
        bit [1:0]  exc;
        bit [31:0] pa0;
        bit [31:0] pa1;
        int        lat;
    } exp_t;

    bit [19:0] vpn_pool [8] = '{20'h00000, 20'h00001, 20'h00002, 20'h00012,
                                20'h00013, 20'hFFFFF, 20'hFFFFE, 20'h00080};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_find(input bit [19:0] vpn);
        for (int i = 0; i < N; i++)
            if (m_v[i] && m_vpn[i] == vpn) return i;
        return -1;
    endfunction

    function automatic bit [1:0] page_fault(input int idx, input bit wr);
        if (idx < 0 || !m_fl[idx][1]) return 2'b10;
        if (wr && !m_fl[idx][0])      return 2'b11;
        return 2'b00;
    endfunction

    function automatic exp_t model(input bit rd, input bit wr, input bit [31:0] lin,
                                   input bit [31:0] soff, input bit [31:0] lim, input bit [1:0] op);
        exp_t      e;
        int        sz, i0, i1;
        bit [11:0] off;
        bit [19:0] vpn;
        e     = '{default: 0};
        e.lat = 1;
        sz    = 1 << op;
        off   = lin[11:0];
        vpn   = lin[31:12];
        if (!(rd || wr)) return e;
        if (longint'(soff) + sz - 1 > longint'(lim)) begin
            e.exc = 2'b01;
            return e;
        end
        i0    = m_find(vpn);
        e.exc = page_fault(i0, wr);
        if (e.exc != 2'b00) return e;
        e.pa0 = {m_pfn[i0], off};
        if (int'(off) + sz <= 4096) return e;
        e.split = 1'b1;
        e.lat   = 2;
        i1      = m_find(vpn + 20'd1);
        e.exc   = page_fault(i1, wr);
        e.pa1   = (i1 >= 0) ? {m_pfn[i1], 12'h000} : 32'h0;
        return e;
    endfunction

    task automatic drive_req(input bit rd, input bit wr, input bit [31:0] lin,
                             input bit [31:0] soff, input bit [31:0] lim, input bit [1:0] op);
        bus.i_v        = 1'b1;
        bus.i_mem_rd   = rd;
        bus.i_mem_wr   = wr;
        bus.i_lin_addr = lin;
        bus.i_seg_off  = soff;
        bus.i_seg_lim  = lim;
        bus.i_opSize   = op;
    endtask

    task automatic idle_req();
        bus.i_v      = 1'b0;
        bus.i_mem_rd = 1'b0;
        bus.i_mem_wr = 1'b0;
    endtask

    task automatic fill(input int idx, input bit [19:0] vpn, input bit [19:0] pfn, input bit [1:0] fl);
        @(negedge clk);
        bus.i_fill_we    = 1'b1;
        bus.i_fill_idx   = IDX_W'(idx);
        bus.i_fill_vpn   = vpn;
        bus.i_fill_pfn   = pfn;
        bus.i_fill_flags = fl;
        @(negedge clk);
        bus.i_fill_we = 1'b0;
        m_v[idx]   = 1'b1;
        m_vpn[idx] = vpn;
        m_pfn[idx] = pfn;
        m_fl[idx]  = fl;
    endtask

    task automatic check_result(input string tag, input exp_t e, input bit rd, input bit wr);
        check({tag, ".v"},     bus.o_v, 1'b1);
        check({tag, ".rd"},    bus.o_mem_rd, rd);
        check({tag, ".wr"},    bus.o_mem_wr, wr);
        check({tag, ".excv"},  bus.o_exc_v, e.exc != 2'b00);
        check({tag, ".code"},  bus.o_exc_code, e.exc);
        check({tag, ".split"}, bus.o_split, e.split);
        check({tag, ".stall"}, bus.o_stall, 1'b0);
        if (e.exc == 2'b00) begin
            check({tag, ".pa0"}, bus.o_pa0, e.pa0);
            check({tag, ".pa1"}, bus.o_pa1, e.pa1);
        end
    endtask

    task automatic access(input string tag, input bit rd, input bit wr, input bit [31:0] lin,
                          input bit [31:0] soff, input bit [31:0] lim, input bit [1:0] op);
        exp_t e;
        e = model(rd, wr, lin, soff, lim, op);
        @(negedge clk);
        drive_req(rd, wr, lin, soff, lim, op);
        @(posedge clk); #1;
        if (e.lat == 2) begin
            check({tag, ".s2stall"}, bus.o_stall, 1'b1);
            check({tag, ".s2v"},     bus.o_v, 1'b0);
            @(posedge clk); #1;
        end
        check_result(tag, e, rd, wr);
        @(negedge clk);
        idle_req();
    endtask

    initial begin
        exp_t e;
        bus.i_flush = 1'b0; bus.i_dc_stall = 1'b0; bus.i_fill_we = 1'b0;
        bus.i_fill_idx = '0; bus.i_fill_vpn = '0; bus.i_fill_pfn = '0; bus.i_fill_flags = '0;
        bus.i_lin_addr = '0; bus.i_seg_off = '0; bus.i_seg_lim = '0; bus.i_opSize = '0;
        idle_req();

        repeat (2) @(posedge clk);
        #1;
        check("rst.v", bus.o_v, 1'b0);
        check("rst.pa0", bus.o_pa0, 32'h0);
        check("rst.excv", bus.o_exc_v, 1'b0);
        check("rst.stall", bus.o_stall, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        fill(0, 20'h00012, 20'h00ABC, 2'b11);
        access("hit", 1, 0, 32'h00012340, 32'h0, 32'hFFFFFFFF, 2'b10);
        check("hit.pa0c", bus.o_pa0, 32'h00ABC340);
        fill(1, 20'h00013, 20'h00777, 2'b11);
        access("split", 1, 0, 32'h00012FFE, 32'h0, 32'hFFFFFFFF, 2'b10);
        access("gp", 1, 0, 32'h00099000, 32'h0000FFFE, 32'h0000FFFF, 2'b10);
        access("gpcarry", 0, 1, 32'h00012000, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01);
        access("nomem", 0, 0, 32'h00012340, 32'h0, 32'h0, 2'b11);

        // Downstream stall holds the registered result while a new request waits.
        access("hold.hit", 1, 0, 32'h00012340, 32'h0, 32'hFFFFFFFF, 2'b10);
        bus.i_dc_stall = 1'b1;
        drive_req(1, 0, 32'h00013004, 32'h0, 32'hFFFFFFFF, 2'b10);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("hold.v", bus.o_v, 1'b1);
            check("hold.pa0", bus.o_pa0, 32'h00ABC340);
            check("hold.stall", bus.o_stall, 1'b1);
        end
        @(negedge clk);
        bus.i_dc_stall = 1'b0;
        e = model(1, 0, 32'h00013004, 32'h0, 32'hFFFFFFFF, 2'b10);
        @(posedge clk); #1;
        check_result("hold.next", e, 1, 0);
        @(negedge clk);
        idle_req();

        // Flush while in the second half of a split.
        @(negedge clk);
        drive_req(1, 0, 32'h00012FFE, 32'h0, 32'hFFFFFFFF, 2'b10);
        @(posedge clk); #1;
        check("flush.s2", bus.o_stall, 1'b1);
        @(negedge clk);
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        check("flush.v", bus.o_v, 1'b0);
        check("flush.stall", bus.o_stall, 1'b0);
        @(negedge clk);
        bus.i_flush = 1'b0;
        idle_req();

        // Flush wins over a downstream stall.
        access("fstall.hit", 1, 0, 32'h00012340, 32'h0, 32'hFFFFFFFF, 2'b00);
        bus.i_dc_stall = 1'b1;
        bus.i_flush    = 1'b1;
        @(posedge clk); #1;
        check("fstall.v", bus.o_v, 1'b0);
        @(negedge clk);
        bus.i_dc_stall = 1'b0;
        bus.i_flush    = 1'b0;

        // Downstream stall during the split's second lookup.
        e = model(1, 0, 32'h00012FFE, 32'h0, 32'hFFFFFFFF, 2'b10);
        @(negedge clk);
        drive_req(1, 0, 32'h00012FFE, 32'h0, 32'hFFFFFFFF, 2'b10);
        @(posedge clk); #1;
        @(negedge clk);
        bus.i_dc_stall = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("s2hold.v", bus.o_v, 1'b0);
            check("s2hold.stall", bus.o_stall, 1'b1);
        end
        @(negedge clk);
        bus.i_dc_stall = 1'b0;
        @(posedge clk); #1;
        check_result("s2hold.out", e, 1, 0);
        @(negedge clk);
        idle_req();

        fill(0, 20'h00012, 20'h00ABC, 2'b10);
        access("wp", 0, 1, 32'h00012100, 32'h0, 32'hFFFFFFFF, 2'b01);
        access("miss", 1, 0, 32'h00099000, 32'h0, 32'hFFFFFFFF, 2'b10);
        access("p1miss", 1, 0, 32'h00013FFF, 32'h0, 32'hFFFFFFFF, 2'b01);
        fill(2, 20'hFFFFF, 20'h00123, 2'b11);
        fill(3, 20'h00000, 20'h00456, 2'b11);
        access("wrap", 1, 0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFF, 2'b11);

        // A fill and a lookup of the same VPN in one cycle: lookup sees the old contents.
        @(negedge clk);
        bus.i_fill_we = 1'b1; bus.i_fill_idx = IDX_W'(4);
        bus.i_fill_vpn = 20'h00055; bus.i_fill_pfn = 20'h00005; bus.i_fill_flags = 2'b11;
        drive_req(1, 0, 32'h00055010, 32'h0, 32'hFFFFFFFF, 2'b00);
        @(posedge clk); #1;
        check("samefill.code", bus.o_exc_code, 2'b10);
        @(negedge clk);
        bus.i_fill_we = 1'b0;
        idle_req();
        m_v[4] = 1'b1; m_vpn[4] = 20'h00055; m_pfn[4] = 20'h00005; m_fl[4] = 2'b11;
        access("samefill.after", 1, 0, 32'h00055010, 32'h0, 32'hFFFFFFFF, 2'b00);

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(3) == 0) begin
                bit [19:0] v;
                int        j;
                v = vpn_pool[$urandom_range(7)];
                j = m_find(v);
                fill((j >= 0) ? j : int'($urandom_range(N - 1)), v, 20'($urandom), 2'($urandom));
            end else begin
                bit [19:0] v;
                bit [11:0] off;
                bit [31:0] soff, lim;
                v    = ($urandom_range(9) == 0) ? 20'($urandom) : vpn_pool[$urandom_range(7)];
                off  = $urandom_range(1) ? 12'($urandom) : 12'hFF8 + 12'($urandom_range(7));
                soff = $urandom;
                lim  = ($urandom_range(4) == 0) ? soff + $urandom_range(8) : 32'hFFFFFFFF;
                access("rand", 1'($urandom), 1'($urandom), {v, off}, soff, lim, 2'($urandom));
            end
        end

        // Asynchronous reset between edges while a split is in flight.
        @(negedge clk);
        drive_req(1, 0, 32'h00012FFE, 32'h0, 32'hFFFFFFFF, 2'b10);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("arst.v", bus.o_v, 1'b0);
        check("arst.stall", bus.o_stall, 1'b0);
        check("arst.split", bus.o_split, 1'b0);
        check("arst.pa0", bus.o_pa0, 32'h0);
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
        @(negedge clk);
        idle_req();
        @(negedge clk);
        rst = 1'b1;
        access("arst.miss", 1, 0, 32'h00012340, 32'h0, 32'hFFFFFFFF, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
